// File: rtl/occupancy_grid_server_pkg.sv
// occupancy_grid_server_pkg: shared FSM state type, read latency and cell address packing
// for the occupancy-grid server.
package occ_grid_pkg;
   typedef enum logic {IDLE, CLEAR} state_t;
   localparam int READ_LATENCY = 2;
   function automatic logic [31:0] cell_addr(input logic [15:0] x, input logic [15:0] y, input int x_bits);
      return ({16'd0, y} << x_bits) | {16'd0, x};
   endfunction
endpackage

// File: rtl/occupancy_grid_server_if.sv
// occupancy_grid_server_if: cell request/response channel between grid clients and the server.
interface cell_access_bus #(parameter int GRID_WIDTH_LOG2 = 7, parameter int GRID_HEIGHT_LOG2 = 7);
   logic [GRID_WIDTH_LOG2-1:0] cell_x;
   logic [GRID_HEIGHT_LOG2-1:0] cell_y;
   logic vld_in, we, w_occupied;
   logic vld_out, rdy, r_occupied;
   modport server(input cell_x, cell_y, vld_in, we, w_occupied, output vld_out, rdy, r_occupied);
   modport client(output cell_x, cell_y, vld_in, we, w_occupied, input vld_out, rdy, r_occupied);
endinterface

// File: rtl/occupancy_grid_server_bram.sv
// occupancy_grid_server_bram: single-port read-first 1-bit RAM with registered read data.
module occ_grid_bram #(parameter int AW = 14) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic          wd,
   output logic          rd
);
   logic mem [2**AW];
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wd;
      rd <= mem[addr];
   end
endmodule

// File: rtl/occupancy_grid_server.sv
// occupancy_grid_server: pipelined 1-bit-per-cell occupancy grid with automatic full clear.
// Defining OCC_GRID_COUNT_EN adds the occupied_count port and its tracking counter.
module occupancy_grid_server
   import occ_grid_pkg::*;
#(
   parameter int GRID_WIDTH_LOG2  = 7,
   parameter int GRID_HEIGHT_LOG2 = 7
) (
   input  logic  clk,
   input  logic  rst,
   cell_access_bus.server bus,
   input  logic  clear_start,
   output logic  clear_busy,
   output logic  clear_done
`ifdef OCC_GRID_COUNT_EN
   ,
   output logic [GRID_WIDTH_LOG2+GRID_HEIGHT_LOG2:0] occupied_count
`endif
);
   localparam int AW = GRID_WIDTH_LOG2 + GRID_HEIGHT_LOG2;
   state_t state, state_nx;
   logic [AW-1:0] sweep, mem_addr;
   logic mem_we, mem_wd, mem_rd, acc, last;
   logic [READ_LATENCY-1:0] vpipe;
   assign acc  = bus.vld_in && state == IDLE;
   assign last = &sweep;
   assign bus.vld_out = vpipe[READ_LATENCY-1];
   always_ff @(posedge clk) begin
      if (rst) state <= CLEAR;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state == IDLE ? (clear_start ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
   end
   // The clear sweep owns the RAM port; otherwise accepted requests drive it.
   always_comb begin
      bus.rdy    = state == IDLE;
      clear_busy = state == CLEAR;
      mem_we     = state == CLEAR || (acc && bus.we);
      mem_addr   = state == CLEAR ? sweep : AW'(cell_addr(16'(bus.cell_x), 16'(bus.cell_y), GRID_WIDTH_LOG2));
      mem_wd     = state == IDLE && bus.w_occupied;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sweep          <= '0;
         clear_done     <= 1'b0;
         vpipe          <= '0;
         bus.r_occupied <= 1'b0;
      end else begin
         sweep      <= state == CLEAR ? sweep + 1'b1 : '0;
         clear_done <= state == CLEAR && last;
         vpipe      <= {vpipe[READ_LATENCY-2:0], acc};
         if (vpipe[READ_LATENCY-2]) bus.r_occupied <= mem_rd;
      end
   end
   occ_grid_bram #(.AW(AW)) u_bram (
      .clk  (clk),
      .we   (mem_we),
      .addr (mem_addr),
      .wd   (mem_wd),
      .rd   (mem_rd)
   );
`ifdef OCC_GRID_COUNT_EN
   logic we_q, wd_q;
   always_ff @(posedge clk) begin
      we_q <= bus.we;
      wd_q <= bus.w_occupied;
   end
   // Writes retiring during a clear are wiped by the sweep, so they must not count.
   always_ff @(posedge clk) begin
      if (rst || (state == IDLE && clear_start)) occupied_count <= '0;
      else if (vpipe[READ_LATENCY-2] && we_q && state == IDLE)
         occupied_count <= (wd_q && !mem_rd) ? occupied_count + 1'b1 :
                           (!wd_q && mem_rd) ? occupied_count - 1'b1 : occupied_count;
   end
`endif
endmodule
